timer_reg_slave: RTL
====================

Name: timer_reg_slave

Overview:
- Bus-responder register block of the 8-bit timer.
- Answers the CPU-side two-phase bus used by the timer bench CPU model (setup phase: psel; access phase: psel+penable), with optional wait states.
- Holds the timer's three registers: TDR, TCR and TSR.
- Drives control values to the counter core and collects overflow/underflow events from it.

Parameters:
- WAIT_CYCLES, 0, number of extra access-phase cycles before pready asserts (0..15).
- ADDR_W, 8, address bus width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- psel  in  1  slave select.
- penable  in  1  access-phase qualifier.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDR_W  register address.
- pwdata  in  8  write data.
- prdata  out  8  read data; valid only while pready=1.
- pready  out  1  transfer-complete strobe.
- pslverr  out  1  error response; valid only while pready=1.
- ovf_set  in  1  overflow event pulse from counter core.
- udf_set  in  1  underflow event pulse from counter core.
- tdr_o  out  8  TDR value (reload data).
- tcr_o  out  8  TCR value, reserved bits forced 0.
- load_o  out  1  one-cycle reload pulse to counter core.

Behaviour:
- Register map:
  - 0x00 TDR: RW, 8 bits.
  - 0x01 TCR: bit7 load (write-only trigger, reads 0); bits6,3,2 reserved (read 0, writes ignored); bit5 up_dn; bit4 en; bits1:0 cks.
  - 0x02 TSR: bit0 ovf, bit1 udf; bits7:2 read 0.
  - Any other address is invalid.
- Reset (rst_n=0, asynchronous): TDR=0x00, TCR=0x00, TSR=0x00, prdata=0, pready=0, pslverr=0, load_o=0, wait counter=0, FSM=IDLE.
- FSM states:
  - IDLE: psel=1 & penable=0 -> SETUP.
  - SETUP: next cycle -> ACCESS.
  - ACCESS: wait counter counts 0..WAIT_CYCLES. When count==WAIT_CYCLES and psel&penable, pready=1 for exactly that cycle; then -> IDLE.
  - ACCESS with psel dropped (master abort): -> IDLE, no register update, pready stays 0.
- pready is combinationally qualified by psel&penable&(count==WAIT_CYCLES). With WAIT_CYCLES=0, pready=1 in the first access cycle: two-cycle transfer.
- Writes:
  - Commit on the rising edge ending the pready=1 cycle.
  - Register outputs show the new value the following cycle.
  - TCR write with bit7=1 -> load_o=1 for exactly one cycle, the cycle after commit.
- Reads: prdata = addressed register during the pready cycle, 0 otherwise. Invalid address -> prdata=0.
- Errors: invalid address -> pslverr=1 with pready; write ignored.
- TSR flags:
  - Sticky: ovf_set/udf_set set the bit on the next edge.
  - Write-1-to-clear per bit; writing 0 leaves the bit unchanged.
  - Same-edge set and W1C on one bit: set wins (bit stays 1).
- Read of TSR in the same cycle as an ovf_set pulse returns the pre-edge value.
- Back-to-back transfers: a new SETUP may begin the cycle after pready. No dead cycle required beyond FSM return.
- Reset mid-transfer: FSM to IDLE; registers to reset values; pending write lost; no load_o pulse.

Test Plan:
- Reset values: write TDR=0xA5, TCR=0x33; pulse rst_n low 1 cycle -> reads of 0x00, 0x01, 0x02 return 0x00, pslverr=0.
- Read-back, WAIT_CYCLES=0: write TDR=0x5A -> read 0x5A, pready high one cycle in 2nd bus cycle. Write TCR=0xFF -> read 0x33, tcr_o=0x33, load_o pulses once, 1 cycle after commit.
- TSR sticky/W1C: pulse ovf_set -> TSR reads 0x01. Pulse udf_set and write TSR=0x01 on the same edge -> TSR=0x02. Write 0x02 -> 0x00. Pulse ovf_set on a W1C-of-bit0 edge -> bit0 remains 1.
- Invalid address: write 0x07 data 0x99 -> pslverr=1 with pready; TDR/TCR/TSR unchanged. Read 0x07 -> prdata=0x00, pslverr=1.
- Wait states, WAIT_CYCLES=2: write TDR=0x3C -> pready asserts in the 3rd access cycle (4th bus cycle); tdr_o changes only after that edge. Dropping psel in access cycle 2 -> no write, pready never asserts.
- Reset mid-operation: assert rst_n=0 during ACCESS of a TCR=0x90 write -> tcr_o=0x00, load_o never pulses; next transfer completes normally.

Source files
------------

// File: rtl/timer_reg_slave.sv
// Bus-responder register block of the 8-bit timer: TDR/TCR/TSR with optional wait states,
// sticky event flags with write-1-to-clear, and a one-cycle reload strobe to the counter core.
module timer_reg_slave #(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              ovf_set,
    input  logic              udf_set,
    output logic [7:0]        tdr_o,
    output logic [7:0]        tcr_o,
    output logic              load_o
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam logic [3:0] WAIT_MAX = 4'(WAIT_CYCLES);
    localparam logic [7:0] TCR_MASK = 8'h33;

    state_t     state;
    logic [3:0] wait_cnt;
    logic [7:0] tdr;
    logic [7:0] tcr;
    logic [1:0] tsr;

    logic       in_access;
    logic       sel_tdr;
    logic       sel_tcr;
    logic       sel_tsr;
    logic       addr_ok;
    logic       wr_commit;
    logic [1:0] w1c;

    assign in_access = (state == SETUP) || (state == ACCESS);
    assign sel_tdr   = (paddr == ADDR_W'(0));
    assign sel_tcr   = (paddr == ADDR_W'(1));
    assign sel_tsr   = (paddr == ADDR_W'(2));
    assign addr_ok   = sel_tdr | sel_tcr | sel_tsr;

    // SETUP is the first access-phase cycle, so a zero-wait transfer completes in two bus cycles.
    assign pready    = in_access & psel & penable & (wait_cnt == WAIT_MAX);
    assign pslverr   = pready & ~addr_ok;
    assign wr_commit = pready & pwrite & addr_ok;
    assign w1c       = (wr_commit & sel_tsr) ? pwdata[1:0] : 2'b00;

    assign tdr_o = tdr;
    assign tcr_o = tcr;

    always_comb begin
        prdata = 8'h00;
        if (pready && !pwrite) begin
            if (sel_tdr)
                prdata = tdr;
            else if (sel_tcr)
                prdata = tcr;
            else if (sel_tsr)
                prdata = {6'b000000, tsr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= 4'd0;
                    if (psel && !penable)
                        state <= SETUP;
                end
                SETUP, ACCESS: begin
                    if (!psel || pready) begin
                        state    <= IDLE;
                        wait_cnt <= 4'd0;
                    end else begin
                        state <= ACCESS;
                        if (penable && (wait_cnt != WAIT_MAX))
                            wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Event set is applied after the clear so a coincident set wins over W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdr    <= 8'h00;
            tcr    <= 8'h00;
            tsr    <= 2'b00;
            load_o <= 1'b0;
        end else begin
            if (wr_commit && sel_tdr)
                tdr <= pwdata;
            if (wr_commit && sel_tcr)
                tcr <= pwdata & TCR_MASK;
            load_o <= wr_commit & sel_tcr & pwdata[7];
            tsr    <= (tsr & ~w1c) | {udf_set, ovf_set};
        end
    end

endmodule
